// File: rtl/mix_columns_seq.sv
// AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per BUSY cycle; in_last passes the state through.
// Latency 4/COLS_PER_CYCLE+1 cycles (1 with in_last); result held in DONE until out_ready, in_ready low until then.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic [127:0] st_q, st_d;
  logic [127:0] mixed;
  logic [2:0]   cnt_sum;

  // All four columns are mixed combinationally; BUSY writes back only the window at cnt_q.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = mix_col(st_q[32*c +: 32]);
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + STEP;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          last_d  = in_last;
          cnt_d   = 2'd0;
          state_d = in_last ? DONE : BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < 4; c++) begin
          if (!last_q && 3'(c) >= {1'b0, cnt_q} && 3'(c) < cnt_sum) begin
            st_d[32*c +: 32] = mixed[32*c +: 32];
          end
        end
        cnt_d = cnt_sum[1:0];
        // Carry out of the counter marks the last column window.
        if (cnt_sum[2]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 1'b0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      st_q    <= st_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench: three DUTs (1, 2 and 4 columns per cycle) share stimulus; per-instance monitors check data, latency and hold.
module tb_mix_columns_seq;

  typedef struct {
    logic [127:0] d;
    int           acc;
    int           lat;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   vld;
  logic [2:0]   rdy;
  logic [2:0]   ov;
  logic [127:0] od [3];
  logic [127:0] in_data;
  logic         in_last;
  logic         out_ready;
  logic [127:0] exp_dat;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           mode = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (mode == 1) out_ready = 1'b1;
    else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b0;
  end

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[32*c + 8*k +: 8];
      r[32*c +: 8]      = gmul(8'd2, a[0]) ^ gmul(8'd3, a[1]) ^ a[2] ^ a[3];
      r[32*c + 8 +: 8]  = a[0] ^ gmul(8'd2, a[1]) ^ gmul(8'd3, a[2]) ^ a[3];
      r[32*c + 16 +: 8] = a[0] ^ a[1] ^ gmul(8'd2, a[2]) ^ gmul(8'd3, a[3]);
      r[32*c + 24 +: 8] = gmul(8'd3, a[0]) ^ a[1] ^ a[2] ^ gmul(8'd2, a[3]);
    end
    return r;
  endfunction

  function automatic logic [31:0] col(input logic [7:0] r0, input logic [7:0] r1,
                                      input logic [7:0] r2, input logic [7:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = 1 << g;
    item_t        q[$];
    item_t        it;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [127:0] pd = '0;

    mix_columns_seq #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[g]),
      .in_ready  (rdy[g]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (vld[g] && rdy[g]) begin
          it.d   = exp_dat;
          it.acc = cyc;
          it.lat = in_last ? 0 : 4 / C;
          q.push_back(it);
        end
        if (pv && !pr) begin
          chk(ov[g] == 1'b1, $sformatf("c%0d_hold_valid", C), 128'(ov[g]), 128'd1);
          chk(od[g] == pd, $sformatf("c%0d_hold_data", C), od[g], pd);
        end
        if (ov[g] && !pv) begin
          chk(q.size() != 0, $sformatf("c%0d_unexpected_out", C), od[g], '0);
          if (q.size() != 0)
            chk(cyc - q[0].acc - 1 == q[0].lat, $sformatf("c%0d_latency", C),
                128'(cyc - q[0].acc - 1), 128'(q[0].lat));
        end
        if (ov[g] && out_ready && q.size() != 0) begin
          it = q.pop_front();
          chk(od[g] == it.d, $sformatf("c%0d_data", C), od[g], it.d);
        end
        pv = ov[g];
        pr = out_ready;
        pd = od[g];
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic l, input logic [127:0] e);
    logic [2:0] took;
    logic [2:0] got;
    int n;
    got = 3'b000;
    n = 0;
    in_data = d;
    in_last = l;
    exp_dat = e;
    vld = 3'b111;
    while (got != 3'b111 && n < 200) begin
      @(negedge clk);
      took = vld & rdy;
      @(posedge clk);
      #1;
      got = got | took;
      vld = vld & ~took;
      n++;
    end
    chk(got == 3'b111, "accept_timeout", 128'(got), 128'h7);
    vld = 3'b000;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_last = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy == 3'b111 && ov == 3'b000) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(rdy == 3'b111 && ov == 3'b000, "drain", 128'({rdy, ov}), 128'h38);
    @(posedge clk);
    #1;
  endtask

  logic [127:0] fips_in, fips_out, v2_in, v2_out;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_in  = {col(8'h2d, 8'h26, 8'h31, 8'h4c), col(8'h01, 8'h01, 8'h01, 8'h01),
                col(8'hf2, 8'h0a, 8'h22, 8'h5c), col(8'hdb, 8'h13, 8'h53, 8'h45)};
    fips_out = {col(8'h4d, 8'h7e, 8'hbd, 8'hf8), col(8'h01, 8'h01, 8'h01, 8'h01),
                col(8'h9f, 8'hdc, 8'h58, 8'h9d), col(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    v2_in    = {col(8'hdb, 8'h13, 8'h53, 8'h45), col(8'h00, 8'h00, 8'h00, 8'h00),
                col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'hd4, 8'hd4, 8'hd4, 8'hd5)};
    v2_out   = {col(8'h8e, 8'h4d, 8'ha1, 8'hbc), col(8'h00, 8'h00, 8'h00, 8'h00),
                col(8'hc6, 8'hc6, 8'hc6, 8'hc6), col(8'hd5, 8'hd5, 8'hd7, 8'hd6)};

    rst_n = 1'b0;
    vld = 3'b000;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_last = 1'b1;
    exp_dat = '0;
    out_ready = 1'b1;
    #2;
    chk(rdy == 3'b111, "reset_in_ready", 128'(rdy), 128'h7);
    chk(ov == 3'b000, "reset_out_valid", 128'(ov), 128'h0);
    for (int i = 0; i < 3; i++) chk(od[i] == '0, "reset_out_data", od[i], '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS columns, mixed and passed through, then back-to-back states
    send(fips_in, 1'b0, fips_out);
    wait_idle();
    send(fips_in, 1'b1, fips_in);
    wait_idle();
    send(v2_in, 1'b0, v2_out);
    send(fips_in, 1'b0, fips_out);
    send(v2_in, 1'b1, v2_in);
    send('0, 1'b0, '0);
    wait_idle();

    // Backpressure in DONE with ignored in_valid pulses
    mode = 0;
    @(posedge clk);
    #2;
    send(fips_in, 1'b0, fips_out);
    for (int n = 0; n < 50 && ov[0] !== 1'b1; n++) @(negedge clk);
    chk(ov == 3'b111, "bp_reach_done", 128'(ov), 128'h7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      vld = (i % 2 == 0) ? 3'b111 : 3'b000;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_last = 1'($urandom);
      @(negedge clk);
      chk(rdy == 3'b000, "bp_in_ready", 128'(rdy), 128'h0);
      chk(od[0] == fips_out, "bp_out_data", od[0], fips_out);
    end
    @(posedge clk);
    #2;
    vld = 3'b000;
    mode = 1;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk(ov[0] == 1'b1, "bp_valid_until_edge", 128'(ov[0]), 128'h1);
    @(negedge clk);
    chk(ov[0] == 1'b0 && rdy[0] == 1'b1, "bp_back_to_idle", 128'({ov[0], rdy[0]}), 128'h1);
    wait_idle();

    // Reset after two BUSY edges
    mode = 0;
    @(posedge clk);
    #2;
    send(fips_in, 1'b0, fips_out);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(ov == 3'b000, "rst_mid_out_valid", 128'(ov), 128'h0);
    chk(rdy == 3'b111, "rst_mid_in_ready", 128'(rdy), 128'h7);
    for (int i = 0; i < 3; i++) chk(od[i] == '0, "rst_mid_out_data", od[i], '0);
    mode = 1;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(ov == 3'b000, "rst_no_stale", 128'(ov), 128'h0);
    end
    @(posedge clk);
    #1;

    // Random regression
    mode = 2;
    for (int i = 0; i < 1000; i++) begin
      logic [127:0] d;
      logic l;
      d = {$urandom, $urandom, $urandom, $urandom};
      l = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(d, l, l ? d : model(d));
    end
    mode = 1;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
